// File: rtl/button_gesture.sv
// Turns the debounced button level into one-cycle gesture strobes: short, long, repeat and double press.
// Double-press detection is compiled in only when BUTTON_DOUBLE_PRESS_EN is defined.
module button_gesture #(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned LONG_CYCLES   = 16'd50000,
    parameter int unsigned GAP_CYCLES    = 16'd20000,
    parameter int unsigned REPEAT_CYCLES = 16'd10000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic debounced,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic double_press,
    output logic held
);

    // Terminal counts are period-1; a period of 2^CNT_W maps to an all-ones compare.
    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
`ifdef BUTTON_DOUBLE_PRESS_EN
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRESSED,
        LONG_HELD
`ifdef BUTTON_DOUBLE_PRESS_EN
        ,
        WAIT_GAP,
        SECOND_HELD
`endif
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             short_nxt;
    logic             long_nxt;
    logic             repeat_nxt;
`ifdef BUTTON_DOUBLE_PRESS_EN
    logic             double_nxt;
`endif

    assign rise = debounced & ~btn_q;
    assign fall = ~debounced & btn_q;

    // btn_q resets to 1 so a button held through reset is not seen as a new press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            btn_q        <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_press <= 1'b0;
`ifdef BUTTON_DOUBLE_PRESS_EN
            double_press <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            btn_q        <= debounced;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            repeat_press <= repeat_nxt;
`ifdef BUTTON_DOUBLE_PRESS_EN
            double_press <= double_nxt;
`endif
        end
    end

`ifndef BUTTON_DOUBLE_PRESS_EN
    assign double_press = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                if (fall) begin
`ifdef BUTTON_DOUBLE_PRESS_EN
                    state_nxt = WAIT_GAP;
`else
                    state_nxt = IDLE;
`endif
                    cnt_nxt   = '0;
                end else if (cnt == LONG_TC) begin
                    state_nxt = LONG_HELD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == REPEAT_TC) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef BUTTON_DOUBLE_PRESS_EN
            WAIT_GAP: begin
                if (rise) begin
                    state_nxt = SECOND_HELD;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_TC) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SECOND_HELD: begin
                if (fall) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Release always wins over a coincident terminal count.
    always_comb begin
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        repeat_nxt = 1'b0;
`ifdef BUTTON_DOUBLE_PRESS_EN
        double_nxt = 1'b0;
`endif
        held       = 1'b0;
        case (state)
            PRESSED: begin
                held = 1'b1;
                if (fall) begin
`ifndef BUTTON_DOUBLE_PRESS_EN
                    short_nxt = 1'b1;
`endif
                end else if (cnt == LONG_TC) begin
                    long_nxt = 1'b1;
                end
            end
            LONG_HELD: begin
                held = 1'b1;
                if (!fall && cnt == REPEAT_TC) begin
                    repeat_nxt = 1'b1;
                end
            end
`ifdef BUTTON_DOUBLE_PRESS_EN
            WAIT_GAP: begin
                if (rise) begin
                    double_nxt = 1'b1;
                end else if (cnt == GAP_TC) begin
                    short_nxt = 1'b1;
                end
            end
            SECOND_HELD: begin
                held = 1'b1;
            end
`endif
            default: begin
                held = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_gesture.sv
// Cycle-by-cycle vector bench for button_gesture with small interval parameters.
// Builds expectations for whichever BUTTON_DOUBLE_PRESS_EN setting is compiled.
module tb_button_gesture;

    logic clk = 1'b0;
    logic reset_n;
    logic debounced;
    logic short_press;
    logic long_press;
    logic repeat_press;
    logic double_press;
    logic held;

    int checks = 0;
    int errors = 0;

    // exp bit order: {short, long, repeat, double, held}, sampled 1 ns after the edge
    typedef struct {
        string      name;
        logic       rst_n;
        logic       deb;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    button_gesture #(
        .CNT_W        (4),
        .LONG_CYCLES  (8),
        .GAP_CYCLES   (4),
        .REPEAT_CYCLES(3)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .debounced   (debounced),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .double_press(double_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    function automatic void v(string name, logic rst_n, logic deb, int n, logic [4:0] exp);
        vec_t r;
        for (int i = 0; i < n; i++) begin
            r.name  = name;
            r.rst_n = rst_n;
            r.deb   = deb;
            r.exp   = exp;
            vecs.push_back(r);
        end
    endfunction

    task automatic step_check(string name, logic rst_n, logic deb, logic [4:0] exp, int idx);
        logic [4:0] got;
        reset_n   = rst_n;
        debounced = deb;
        @(posedge clk);
        #1;
        got = {short_press, long_press, repeat_press, double_press, held};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got {s,l,r,d,h}=%b expected %b", name, idx, got, exp);
        end
    endtask

    // Long press, release well after the second repeat; no short on release.
    task automatic add_long(string name);
        v(name, 1, 1, 8, 5'b00001);
        v(name, 1, 1, 1, 5'b01001);
        v(name, 1, 1, 2, 5'b00001);
        v(name, 1, 1, 1, 5'b00101);
        v(name, 1, 1, 2, 5'b00001);
        v(name, 1, 1, 1, 5'b00101);
        v(name, 1, 1, 1, 5'b00001);
        v(name, 1, 0, 7, 5'b00000);
    endtask

    // Release exactly on the repeat terminal edge: no repeat strobe.
    task automatic add_long_release_on_repeat(string name);
        v(name, 1, 1, 8, 5'b00001);
        v(name, 1, 1, 1, 5'b01001);
        v(name, 1, 1, 2, 5'b00001);
        v(name, 1, 1, 1, 5'b00101);
        v(name, 1, 1, 2, 5'b00001);
        v(name, 1, 0, 7, 5'b00000);
    endtask

    initial begin
        reset_n   = 1'b0;
        debounced = 1'b0;

        v("reset", 0, 0, 3, 5'b00000);
        v("idle",  1, 0, 2, 5'b00000);

`ifdef BUTTON_DOUBLE_PRESS_EN
        v("short", 1, 1, 3, 5'b00001);
        v("short", 1, 0, 4, 5'b00000);
        v("short", 1, 0, 1, 5'b10000);
        v("short", 1, 0, 5, 5'b00000);

        add_long("long");
        add_long_release_on_repeat("long_rel_tc");

        v("double", 1, 1, 2, 5'b00001);
        v("double", 1, 0, 2, 5'b00000);
        v("double", 1, 1, 1, 5'b00011);
        v("double", 1, 1, 1, 5'b00001);
        v("double", 1, 0, 6, 5'b00000);

        v("double_tie", 1, 1, 2, 5'b00001);
        v("double_tie", 1, 0, 4, 5'b00000);
        v("double_tie", 1, 1, 1, 5'b00011);
        v("double_tie", 1, 1, 9, 5'b00001);
        v("double_tie", 1, 0, 6, 5'b00000);

        // Release on the long terminal edge takes the short path.
        v("fall_vs_long", 1, 1, 8, 5'b00001);
        v("fall_vs_long", 1, 0, 4, 5'b00000);
        v("fall_vs_long", 1, 0, 1, 5'b10000);
        v("fall_vs_long", 1, 0, 3, 5'b00000);

        v("held_thru_reset", 0, 1, 2, 5'b00000);
        v("held_thru_reset", 1, 1, 5, 5'b00000);
        v("held_thru_reset", 1, 0, 1, 5'b00000);
        v("held_thru_reset", 1, 1, 2, 5'b00001);
        v("held_thru_reset", 1, 0, 4, 5'b00000);
        v("held_thru_reset", 1, 0, 1, 5'b10000);
        v("held_thru_reset", 1, 0, 2, 5'b00000);
`else
        v("short", 1, 1, 3, 5'b00001);
        v("short", 1, 0, 1, 5'b10000);
        v("short", 1, 0, 6, 5'b00000);

        add_long("long");
        add_long_release_on_repeat("long_rel_tc");

        v("two_singles", 1, 1, 2, 5'b00001);
        v("two_singles", 1, 0, 1, 5'b10000);
        v("two_singles", 1, 0, 1, 5'b00000);
        v("two_singles", 1, 1, 2, 5'b00001);
        v("two_singles", 1, 0, 1, 5'b10000);
        v("two_singles", 1, 0, 3, 5'b00000);

        v("fall_vs_long", 1, 1, 8, 5'b00001);
        v("fall_vs_long", 1, 0, 1, 5'b10000);
        v("fall_vs_long", 1, 0, 3, 5'b00000);

        v("held_thru_reset", 0, 1, 2, 5'b00000);
        v("held_thru_reset", 1, 1, 5, 5'b00000);
        v("held_thru_reset", 1, 0, 1, 5'b00000);
        v("held_thru_reset", 1, 1, 2, 5'b00001);
        v("held_thru_reset", 1, 0, 1, 5'b10000);
        v("held_thru_reset", 1, 0, 2, 5'b00000);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            step_check(vecs[i].name, vecs[i].rst_n, vecs[i].deb, vecs[i].exp, i);
        end

        // Hand sequence: reset asserted while a short press is pending.
        for (int i = 0; i < 2; i++) step_check("rst_gap_press", 1, 1, 5'b00001, i);
`ifdef BUTTON_DOUBLE_PRESS_EN
        for (int i = 0; i < 2; i++) step_check("rst_gap_wait", 1, 0, 5'b00000, i);
`else
        step_check("rst_gap_wait", 1, 0, 5'b10000, 0);
        step_check("rst_gap_wait", 1, 0, 5'b00000, 1);
`endif
        for (int i = 0; i < 2; i++) step_check("rst_gap_reset", 0, 0, 5'b00000, i);
        for (int i = 0; i < 10; i++) step_check("rst_gap_after", 1, 0, 5'b00000, i);

        // Hand sequence: once long is reached, holding keeps repeating every 3 cycles.
        for (int i = 0; i < 8; i++) step_check("repeat_run", 1, 1, 5'b00001, i);
        step_check("repeat_run", 1, 1, 5'b01001, 8);
        for (int k = 0; k < 4; k++) begin
            step_check("repeat_run", 1, 1, 5'b00001, 9 + 3 * k);
            step_check("repeat_run", 1, 1, 5'b00001, 10 + 3 * k);
            step_check("repeat_run", 1, 1, 5'b00101, 11 + 3 * k);
        end
        for (int i = 0; i < 6; i++) step_check("repeat_release", 1, 0, 5'b00000, i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
